// File: rtl/encoder_ctrl_pkg.sv
// Shared types and helpers for the combine_encoder front-end arbiter.
package encoder_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_BURST,
      S_WAIT_FIN,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic SEL_UDP = 1'b0;
   localparam logic SEL_TCP = 1'b1;

   function automatic logic [15:0] words_from_len(input logic [15:0] len);
      return (len + 16'd3) >> 2;
   endfunction

   // Bytes past the payload end in the final word are zeroed; first byte sits in [31:24].
   function automatic logic [31:0] last_word_mask(input logic [1:0] rem);
      case (rem)
         2'd1:    return 32'hFF00_0000;
         2'd2:    return 32'hFFFF_0000;
         2'd3:    return 32'hFFFF_FF00;
         default: return '1;
      endcase
   endfunction

endpackage

// File: rtl/tx_word_buf.sv
// Payload word store: one write port, one registered read port with write forwarding.
module tx_word_buf #(
   parameter int unsigned MAX_WORDS = 16,
   localparam int unsigned AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [MAX_WORDS];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // A one-word packet reads the slot being written in the same cycle, so forward it.
   always_ff @(posedge clk) begin
      if (reset)
         rdata <= '0;
      else if (re)
         rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
      else
         rdata <= '0;
   end

endmodule

// File: rtl/encoder_tx_arbiter.sv
// UDP/TCP arbiter that buffers a packet and replays it to combine_encoder as a gap-free burst.
module encoder_tx_arbiter
   import encoder_ctrl_pkg::*;
#(
   parameter int unsigned MAX_WORDS   = 16,
   parameter int unsigned FIN_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        udp_req,
   input  logic [15:0] udp_len,
   input  logic [31:0] udp_data,
   input  logic        udp_valid,
   output logic        udp_ready,
   output logic        udp_done,
   output logic        udp_err,
   input  logic        tcp_req,
   input  logic [15:0] tcp_len,
   input  logic [31:0] tcp_data,
   input  logic        tcp_valid,
   output logic        tcp_ready,
   output logic        tcp_done,
   output logic        tcp_err,
   output logic [31:0] enc_data,
   output logic        enc_start,
   output logic        enc_data_av,
   output logic        enc_udp0_tcp1,
   output logic [15:0] enc_len_udp,
   output logic [15:0] enc_len_tcp,
   input  logic        enc_fin,
   output logic        busy,
   output logic        grant
);

   localparam int unsigned AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam int unsigned TW = (FIN_TIMEOUT > 1) ? $clog2(FIN_TIMEOUT) : 1;

   state_t        state;
   logic [15:0]   nwords, wcnt, rcnt;
   logic [TW-1:0] tcnt;

   logic          sel_valid, load_last, buf_we, buf_re, pick_tcp, len_bad;
   logic [31:0]   sel_data, buf_wdata;
   logic [15:0]   pick_len;

   always_comb begin
      sel_valid = (grant == SEL_TCP) ? tcp_valid : udp_valid;
      sel_data  = (grant == SEL_TCP) ? tcp_data  : udp_data;
      load_last = (wcnt == nwords - 16'd1);
      buf_we    = (state == S_LOAD) && sel_valid && (udp_ready || tcp_ready);
      buf_wdata = load_last ? (sel_data & last_word_mask(enc_len_udp[1:0])) : sel_data;
      // Word 0 is fetched during the final LOAD cycle so the burst starts without a bubble.
      buf_re    = (buf_we && load_last) || ((state == S_BURST) && (rcnt != nwords));
      pick_tcp  = tcp_req && (!udp_req || (grant == SEL_UDP));
      pick_len  = pick_tcp ? tcp_len : udp_len;
      len_bad   = (pick_len == '0) || (32'(pick_len) > 4 * MAX_WORDS);
   end

   tx_word_buf #(.MAX_WORDS(MAX_WORDS)) u_buf (
      .clk   (clk),
      .reset (reset),
      .we    (buf_we),
      .waddr (wcnt[AW-1:0]),
      .wdata (buf_wdata),
      .re    (buf_re),
      .raddr (rcnt[AW-1:0]),
      .rdata (enc_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         grant         <= SEL_TCP;
         busy          <= 1'b0;
         udp_ready     <= 1'b0;
         tcp_ready     <= 1'b0;
         udp_done      <= 1'b0;
         tcp_done      <= 1'b0;
         udp_err       <= 1'b0;
         tcp_err       <= 1'b0;
         enc_start     <= 1'b0;
         enc_data_av   <= 1'b0;
         enc_udp0_tcp1 <= 1'b0;
         enc_len_udp   <= '0;
         enc_len_tcp   <= '0;
         nwords        <= '0;
         wcnt          <= '0;
         rcnt          <= '0;
         tcnt          <= '0;
      end else begin
         udp_done <= 1'b0;
         tcp_done <= 1'b0;
         udp_err  <= 1'b0;
         tcp_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (udp_req || tcp_req) begin
                  grant  <= pick_tcp;
                  busy   <= 1'b1;
                  nwords <= words_from_len(pick_len);
                  wcnt   <= '0;
                  rcnt   <= '0;
                  if (len_bad) begin
                     state   <= S_ERR;
                     udp_err <= !pick_tcp;
                     tcp_err <= pick_tcp;
                  end else begin
                     state         <= S_LOAD;
                     udp_ready     <= !pick_tcp;
                     tcp_ready     <= pick_tcp;
                     enc_udp0_tcp1 <= pick_tcp;
                     enc_len_udp   <= pick_len;
                     enc_len_tcp   <= pick_len;
                  end
               end
            end
            S_LOAD: begin
               if (buf_we) begin
                  wcnt <= wcnt + 16'd1;
                  if (load_last) begin
                     state       <= S_BURST;
                     udp_ready   <= 1'b0;
                     tcp_ready   <= 1'b0;
                     enc_start   <= 1'b1;
                     enc_data_av <= 1'b1;
                     rcnt        <= rcnt + 16'd1;
                  end
               end
            end
            S_BURST: begin
               if (rcnt == nwords) begin
                  state       <= S_WAIT_FIN;
                  enc_start   <= 1'b0;
                  enc_data_av <= 1'b0;
                  tcnt        <= '0;
               end else begin
                  rcnt <= rcnt + 16'd1;
               end
            end
            S_WAIT_FIN: begin
               if (enc_fin || (tcnt == TW'(FIN_TIMEOUT - 1))) begin
                  state         <= enc_fin ? S_DONE : S_ERR;
                  udp_done      <= enc_fin && (grant == SEL_UDP);
                  tcp_done      <= enc_fin && (grant == SEL_TCP);
                  udp_err       <= !enc_fin && (grant == SEL_UDP);
                  tcp_err       <= !enc_fin && (grant == SEL_TCP);
                  enc_udp0_tcp1 <= 1'b0;
                  enc_len_udp   <= '0;
                  enc_len_tcp   <= '0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            S_DONE, S_ERR: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
